// File: rtl/jtpang_sdram_resp_if.sv
// Four-bank ROM request bus between the bank requesters, the responder and
// the backing memory read port. The master side is the requester/memory end,
// the slave side is the responder.
interface jtpang_sdram_resp_if #(
   parameter int AW = 22
);
   logic [AW-1:0]   ba0_addr;
   logic [AW-1:0]   ba1_addr;
   logic [AW-1:0]   ba2_addr;
   logic [AW-1:0]   ba3_addr;
   logic [3:0]      ba_rd;
   logic [3:0]      ba_ack;
   logic [3:0]      ba_dst;
   logic [3:0]      ba_dok;
   logic [3:0]      ba_rdy;
   logic [15:0]     data_read;
   logic [AW+1:0]   mem_addr;
   logic            mem_rd;
   logic [15:0]     mem_dout;

   modport master (
      output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, mem_dout,
      input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd
   );

   modport slave (
      input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, mem_dout,
      output ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd
   );
endinterface

// File: rtl/jtpang_sdram_resp.sv
// Responder for the four-bank ROM request bus. Serves one fixed-length burst
// at a time from a synchronous 16-bit memory read port, picking banks in
// round-robin order. Stands in for the SDRAM controller in simulation and in
// SDRAM-less builds.
module jtpang_sdram_resp #(
   parameter int AW      = 22,
   parameter int BURST   = 2,
   parameter int LATENCY = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   jtpang_sdram_resp_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACK, WAIT, XFER} state_t;

   // The ACK cycle already holds LATENCY-1, so WAIT lasts LATENCY-1 cycles
   // and the first word lands LATENCY cycles after the ack pulse.
   localparam logic [1:0] LAST_WORD = 2'(BURST - 1);
   localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);

   state_t          state;
   logic [1:0]      bank;
   logic [1:0]      rr_ptr;
   logic [1:0]      word;
   logic [3:0]      cnt;
   logic [AW-1:0]   addr;

   logic            found;
   logic [1:0]      pick;
   logic [AW-1:0]   pick_addr;
   logic [3:0]      bank_hot;
   logic [3:0]      pick_hot;

   logic [3:0]      ack_q;
   logic [3:0]      dst_q;
   logic [3:0]      rdy_q;
   logic            rd_q;
   logic [AW+1:0]   maddr_q;
   logic [15:0]     hold_q;

   assign bank_hot = 4'b0001 << bank;
   assign pick_hot = 4'b0001 << pick;

   // Round-robin scan: first requesting bank at or after rr_ptr, modulo 4.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr;
      for (int i = 0; i < 4; i++) begin
         if (!found && bus.ba_rd[rr_ptr + 2'(i)]) begin
            found = 1'b1;
            pick  = rr_ptr + 2'(i);
         end
      end
   end

   // Address of the bank chosen by the scan, latched on grant.
   always_comb begin
      case (pick)
         2'd0:    pick_addr = bus.ba0_addr;
         2'd1:    pick_addr = bus.ba1_addr;
         2'd2:    pick_addr = bus.ba2_addr;
         default: pick_addr = bus.ba3_addr;
      endcase
   end

   // Main sequencer: grant, latency countdown, then back-to-back burst words
   // with the next memory read issued alongside the current word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         bank    <= 2'd0;
         rr_ptr  <= 2'd0;
         word    <= 2'd0;
         cnt     <= 4'd0;
         addr    <= '0;
         ack_q   <= 4'd0;
         dst_q   <= 4'd0;
         rdy_q   <= 4'd0;
         rd_q    <= 1'b0;
         maddr_q <= '0;
         hold_q  <= 16'd0;
      end else begin
         ack_q <= 4'd0;
         dst_q <= 4'd0;
         rdy_q <= 4'd0;
         rd_q  <= 1'b0;
         if (state == XFER) begin
            hold_q <= bus.mem_dout;
         end
         case (state)
            IDLE: begin
               if (found) begin
                  bank  <= pick;
                  addr  <= pick_addr;
                  ack_q <= pick_hot;
                  cnt   <= CNT_INIT;
                  state <= ACK;
               end
            end
            ACK: begin
               cnt   <= cnt - 4'd1;
               state <= WAIT;
               if (cnt == 4'd1) begin
                  rd_q    <= 1'b1;
                  maddr_q <= {bank, addr};
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= XFER;
                  word  <= 2'd0;
                  dst_q <= bank_hot;
                  if (LAST_WORD == 2'd0) begin
                     rdy_q <= bank_hot;
                  end else begin
                     rd_q    <= 1'b1;
                     maddr_q <= {bank, addr + AW'(1)};
                  end
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     rd_q    <= 1'b1;
                     maddr_q <= {bank, addr};
                  end
               end
            end
            XFER: begin
               if (word == LAST_WORD) begin
                  state  <= IDLE;
                  rr_ptr <= bank + 2'd1;
               end else begin
                  word  <= word + 2'd1;
                  dst_q <= bank_hot;
                  if ((word + 2'd1) == LAST_WORD) begin
                     rdy_q <= bank_hot;
                  end else begin
                     rd_q    <= 1'b1;
                     maddr_q <= {bank, addr + AW'(word) + AW'(2)};
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ba_ack    = ack_q;
   assign bus.ba_dst    = dst_q;
   assign bus.ba_dok    = dst_q;
   assign bus.ba_rdy    = rdy_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_addr  = maddr_q;
   assign bus.data_read = (state == XFER) ? bus.mem_dout : hold_q;

endmodule

// File: tb/tb_jtpang_sdram_resp.sv
// Bench for jtpang_sdram_resp: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-timing model.
module tb_jtpang_sdram_resp;
   localparam int L = 4;
   localparam int B = 2;
   localparam int RING = 64;

   logic clk;
   logic rst_n;
   logic [3:0] hold;

   int vectors;
   int miscompares;

   int gLog[$];
   int rLog[$];
   int ackCyc[$];
   int rdyCyc[$];
   logic [15:0] dLog[$];
   logic [23:0] aLog[$];

   jtpang_sdram_resp_if #(.AW(22)) bus ();

   jtpang_sdram_resp #(.AW(22), .BURST(B), .LATENCY(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backing memory content: two fixed words plus a hash of the address.
   function automatic logic [15:0] memWord(input logic [23:0] a);
      if (a == 24'h000010) return 16'h1234;
      if (a == 24'h000011) return 16'h5678;
      return 16'(a[15:0] * 16'd40503) ^ {6'd0, a[23:14]};
   endfunction

   // Synchronous memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_dout <= memWord(bus.mem_addr);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic int hotIndex(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [21:0] bankAddr(input int b);
      case (b)
         0:       return bus.ba0_addr;
         1:       return bus.ba1_addr;
         2:       return bus.ba2_addr;
         default: return bus.ba3_addr;
      endcase
   endfunction

   // Reference model and monitor: each grant schedules its ack, reads, words
   // and done pulse at fixed offsets; every cycle is compared to the schedule.
   initial begin
      logic [3:0]  eAck[RING];
      logic [3:0]  eDst[RING];
      logic [3:0]  eRdy[RING];
      logic        eRd[RING];
      logic [23:0] eAddr[RING];
      logic [15:0] eData[RING];
      logic        eZero[RING];
      int k, s, freeFrom, rr, b;
      logic [21:0] a;
      for (int i = 0; i < RING; i++) begin
         eAck[i] = 0; eDst[i] = 0; eRdy[i] = 0; eRd[i] = 0;
         eAddr[i] = 0; eData[i] = 0; eZero[i] = 0;
      end
      k = 0; freeFrom = 0; rr = 0;
      forever begin
         @(negedge clk);
         k++;
         s = k % RING;
         checkOutput("ba_ack", bus.ba_ack, eAck[s]);
         checkOutput("ba_dst", bus.ba_dst, eDst[s]);
         checkOutput("ba_dok", bus.ba_dok, eDst[s]);
         checkOutput("ba_rdy", bus.ba_rdy, eRdy[s]);
         checkOutput("mem_rd", bus.mem_rd, eRd[s]);
         if (eRd[s]) checkOutput("mem_addr", bus.mem_addr, eAddr[s]);
         if (eDst[s] != 0) checkOutput("data_read", bus.data_read, eData[s]);
         if (eZero[s]) begin
            checkOutput("rst_data_read", bus.data_read, 0);
            checkOutput("rst_mem_addr", bus.mem_addr, 0);
         end
         checkOutput("onehot", ($countones(bus.ba_ack | bus.ba_dst | bus.ba_rdy) > 1), 0);
         if (bus.ba_ack != 0) begin gLog.push_back(hotIndex(bus.ba_ack)); ackCyc.push_back(k); end
         if (bus.ba_rdy != 0) begin rLog.push_back(hotIndex(bus.ba_rdy)); rdyCyc.push_back(k); end
         if (bus.ba_dst != 0) dLog.push_back(bus.data_read);
         if (bus.mem_rd) aLog.push_back(bus.mem_addr);
         eAck[s] = 0; eDst[s] = 0; eRdy[s] = 0; eRd[s] = 0; eZero[s] = 0;

         if (!rst_n) begin
            for (int i = 0; i < RING; i++) begin
               eAck[i] = 0; eDst[i] = 0; eRdy[i] = 0; eRd[i] = 0; eZero[i] = 0;
            end
            eZero[(k + 1) % RING] = 1;
            freeFrom = k + 1;
            rr = 0;
         end else if (k >= freeFrom && bus.ba_rd != 0) begin
            b = -1;
            for (int i = 0; i < 4; i++)
               if (b < 0 && bus.ba_rd[(rr + i) % 4]) b = (rr + i) % 4;
            a = bankAddr(b);
            eAck[(k + 1) % RING] = 4'(1 << b);
            for (int w = 0; w < B; w++) begin
               eRd[(k + L + w) % RING]       = 1;
               eAddr[(k + L + w) % RING]     = {2'(b), a + 22'(w)};
               eDst[(k + 1 + L + w) % RING]  = 4'(1 << b);
               eData[(k + 1 + L + w) % RING] = memWord({2'(b), a + 22'(w)});
            end
            eRdy[(k + L + B) % RING] = 4'(1 << b);
            freeFrom = k + L + B + 1;
            rr = (b + 1) % 4;
         end
      end
   end

   // One clock; requesters drop a level request once it has been acked
   // unless told to hold it.
   task automatic stepCycle();
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++)
         if (bus.ba_ack[b] && !hold[b]) bus.ba_rd[b] = 1'b0;
   endtask

   task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] hd);
      bus.ba_rd = bus.ba_rd | rd;
      hold      = hd;
   endtask

   task automatic clearLogs();
      gLog.delete(); rLog.delete(); ackCyc.delete(); rdyCyc.delete();
      dLog.delete(); aLog.delete();
   endtask

   task automatic doReset(input int n);
      rst_n = 1'b0;
      bus.ba_rd = 4'd0;
      hold = 4'd0;
      repeat (n) stepCycle();
      rst_n = 1'b1;
      clearLogs();
   endtask

   task automatic waitRdy(input int n, input int budget);
      int c = 0;
      while (rLog.size() < n && c < budget) begin stepCycle(); c++; end
      checkOutput("rdy_timeout", (rLog.size() >= n), 1);
   endtask

   task automatic waitAck(input int n, input int budget);
      int c = 0;
      while (gLog.size() < n && c < budget) begin stepCycle(); c++; end
      checkOutput("ack_timeout", (gLog.size() >= n), 1);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int c;
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      hold = 4'd0;
      bus.ba_rd = 4'd0;
      bus.ba0_addr = 22'h0; bus.ba1_addr = 22'h0;
      bus.ba2_addr = 22'h0; bus.ba3_addr = 22'h0;

      doReset(3);
      checkOutput("reset_ack", bus.ba_ack, 0);
      checkOutput("reset_mem_addr", bus.mem_addr, 0);
      checkOutput("reset_data_read", bus.data_read, 0);

      // Single request from bank 0.
      $display("[TB] single request");
      bus.ba0_addr = 22'h000010;
      applyStimulus(4'b0001, 4'b0000);
      waitRdy(1, 50);
      checkOutput("single_grant", gLog[0], 0);
      checkOutput("single_rdy", rLog[0], 0);
      checkOutput("single_word0", dLog[0], 16'h1234);
      checkOutput("single_word1", dLog[1], 16'h5678);
      checkOutput("single_ack_to_rdy", rdyCyc[0] - ackCyc[0], 5);
      repeat (3) stepCycle();

      // All four banks at once straight after reset.
      $display("[TB] four simultaneous requests");
      doReset(1);
      bus.ba0_addr = 22'($urandom); bus.ba1_addr = 22'($urandom);
      bus.ba2_addr = 22'($urandom); bus.ba3_addr = 22'($urandom);
      applyStimulus(4'b1111, 4'b0000);
      waitRdy(4, 120);
      for (int i = 0; i < 4; i++) begin
         checkOutput("rr_grant", gLog[i], i);
         checkOutput("rr_rdy", rLog[i], i);
      end
      repeat (3) stepCycle();

      // Bank 0 holds its request; bank 2 must still get the second slot.
      $display("[TB] fairness");
      doReset(1);
      applyStimulus(4'b0101, 4'b0001);
      waitAck(4, 150);
      checkOutput("fair_g0", gLog[0], 0);
      checkOutput("fair_g1", gLog[1], 2);
      checkOutput("fair_g2", gLog[2], 0);
      checkOutput("fair_g3", gLog[3], 0);
      hold = 4'd0;
      bus.ba_rd = 4'd0;
      repeat (20) stepCycle();

      // Address wrap on bank 3; the address moves after the latch.
      $display("[TB] address wrap");
      clearLogs();
      bus.ba3_addr = 22'h3FFFFF;
      applyStimulus(4'b1000, 4'b0000);
      repeat (3) stepCycle();
      bus.ba3_addr = 22'h123456;
      waitRdy(1, 50);
      checkOutput("wrap_addr0", aLog[0], 24'hFFFFFF);
      checkOutput("wrap_addr1", aLog[1], 24'hC00000);
      repeat (3) stepCycle();

      // Request dropped right after the ack: burst still completes.
      $display("[TB] early drop");
      clearLogs();
      bus.ba1_addr = 22'($urandom);
      applyStimulus(4'b0010, 4'b0000);
      waitRdy(1, 50);
      checkOutput("drop_rdy", rLog[0], 1);
      checkOutput("drop_words", dLog.size(), B);
      repeat (3) stepCycle();

      // Reset while bank 2 is on its first word.
      $display("[TB] reset mid-burst");
      clearLogs();
      applyStimulus(4'b0100, 4'b0000);
      c = 0;
      while (!bus.ba_dst[2] && c < 30) begin stepCycle(); c++; end
      checkOutput("xfer_timeout", bus.ba_dst[2], 1);
      rst_n = 1'b0;
      stepCycle();
      checkOutput("midrst_dst", bus.ba_dst, 0);
      checkOutput("midrst_rdy", bus.ba_rdy, 0);
      checkOutput("midrst_data", bus.data_read, 0);
      checkOutput("midrst_addr", bus.mem_addr, 0);
      rst_n = 1'b1;
      applyStimulus(4'b0010, 4'b0000);
      waitRdy(1, 50);
      checkOutput("midrst_next_rdy", rLog[0], 1);
      checkOutput("midrst_rdy_count", rLog.size(), 1);
      repeat (3) stepCycle();

      // Random traffic with moving addresses, held requests and rare resets.
      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         stepCycle();
         bus.ba0_addr = 22'($urandom); bus.ba1_addr = 22'($urandom);
         bus.ba2_addr = 22'($urandom); bus.ba3_addr = 22'($urandom);
         for (int b = 0; b < 4; b++) begin
            if (!bus.ba_rd[b] && $urandom_range(3) == 0) begin
               bus.ba_rd[b] = 1'b1;
               hold[b] = ($urandom_range(7) == 0);
            end else if (hold[b] && $urandom_range(15) == 0) begin
               hold[b] = 1'b0;
            end
         end
         rst_n = ($urandom_range(149) != 0);
      end
      rst_n = 1'b1;
      hold = 4'd0;
      bus.ba_rd = 4'd0;
      repeat (30) stepCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
